instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential instruction encoder/loader, the producer-side counterpart of the main control decoder.
- Accepts decoded instruction descriptors over a valid/ready handshake.
- Packs each descriptor into a 32-bit MIPS word using the supported opcode set (R, ADDI, SLTIU, BEQ, ORI, BNE, LW, SW).
- Writes the words sequentially into instruction memory starting at a programmable base; used for boot/program loading and by decoder round-trip benches.

Parameters:
- ADDR_W, 32, width of memory byte address.
- MAX_WORDS, 256, maximum words per load session (must be ≤ 32768).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  begin session; base_i sampled; ignored in RUN.
- base_i  in  ADDR_W  byte base address, word aligned.
- req_valid_i  in  1  descriptor valid.
- req_ready_o  out  1  descriptor accepted when valid&ready.
- kind_i  in  3  0=R, 1=ADDI, 2=SLTIU, 3=BEQ, 4=ORI, 5=BNE, 6=LW, 7=SW.
- rs_i, rt_i, rd_i  in  5 each  register fields.
- funct_i  in  6  R-type function code.
- imm_i  in  16  immediate/offset.
- last_i  in  1  marks final descriptor of session.
- we_o  out  1  imem write strobe.
- waddr_o  out  ADDR_W  imem byte address.
- wdata_o  out  32  encoded word.
- count_o  out  16  words written this session.
- done_o  out  1  session complete.
- err_o  out  2  sticky; bit0 illegal funct, bit1 overflow.

Behaviour:
- Reset: state=IDLE; we_o=0, waddr_o=0, wdata_o=0, count_o=0, done_o=0, err_o=0, req_ready_o=0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start_i → RUN. Load base, clear count_o/err_o/done_o.
  - RUN: req_ready_o=1 while count_o<MAX_WORDS.
  - Accepted descriptor with last_i=1 → DONE after its write cycle; done_o=1 until the next start_i.
  - count_o reaching MAX_WORDS with no last_i seen → DONE, err_o[1]=1.
- Encoding:
  - R: {6'd0, rs, rt, rd, 5'd0, funct}.
  - All others: {op, rs, rt, imm}, with op = ADDI 8, SLTIU 9, BEQ 4, ORI 13, BNE 5, LW 35, SW 43.
- Latency: write is registered, so we_o=1 exactly one cycle after the handshake.
  - waddr_o = base + 4*count_o, sampled before increment.
  - count_o increments in that same write cycle.
- Illegal funct: R with funct not in {32 add, 34 sub, 36 and, 37 or, 42 slt}.
  - Descriptor is consumed; no write, no count increment; err_o[0] set.
  - Still counts as last if last_i=1.
- Full throughput: one descriptor per cycle in RUN; back-to-back handshakes give back-to-back writes.
- req_valid_i outside RUN: ignored, no state change.
- Async reset mid-session: immediate return to reset values; any pending write is dropped.

Optional Feature:
- Macro INSTR_ENC_BRANCH_REL_EN.
- Defined: for BEQ/BNE, imm_i is an absolute target word index within the session. Encoded offset = imm_i − (count_o+1), truncated to 16 bits. No range error is possible given the MAX_WORDS limit.
- Undefined: imm_i is inserted verbatim for branches.

Decomposition:
- Shared package instr_pkg holds:
  - opcode constants (OP_R, OP_ADDI, OP_SLTIU, OP_BEQ, OP_ORI, OP_BNE, OP_LW, OP_SW);
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT);
  - kind enum;
  - state enum.
  The decoder's opcode list migrates to this package.
- One combinational sub-module, instr_field_pack: kind, fields → 32-bit word + illegal flag.
- Top holds FSM, counter, output register.

Test Plan:
- Reset, start_i base=0x100, ADDI rs=0 rt=8 imm=5 with last → we_o pulse next cycle, waddr_o=0x100, wdata_o=0x20080005, count_o=1, done_o=1.
- Back-to-back: R add rs=1 rt=2 rd=3 funct=32; LW rs=1 rt=2 imm=4; SW same fields → consecutive writes 0x00221820 @0x100, 0x8C220004 @0x104, 0xAC220004 @0x108.
- R with funct=0 then ADDI → err_o=01, only one write, at base+0, count_o=1.
- MAX_WORDS=4 overrides, 4 descriptors with no last → DONE, err_o=10, req_ready_o=0, 5th valid ignored.
- BEQ rs=1 rt=2 imm=3 (macro off) → 0x10220003. With macro on, at count_o=2 and imm=0 → 0x1022FFFD.
- rst_i low during RUN after one accept → outputs zero immediately, no write after release; start_i restarts with count_o=0.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared MIPS opcode/funct constants plus the kind and state enums used by the instruction encoder.
package instr_pkg;

    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd9;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        KIND_R     = 3'd0,
        KIND_ADDI  = 3'd1,
        KIND_SLTIU = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ORI   = 3'd4,
        KIND_BNE   = 3'd5,
        KIND_LW    = 3'd6,
        KIND_SW    = 3'd7
    } InstrKind;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } EncState;

    function automatic logic isLegalFunct(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: turns a decoded descriptor into a 32-bit MIPS word and flags unsupported R-type functs.
module instr_field_pack
    import instr_pkg::*;
(
    input  InstrKind    kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [5:0] opcode;

    always_comb begin
        opcode = OP_R;
        case (kind)
            KIND_R:     opcode = OP_R;
            KIND_ADDI:  opcode = OP_ADDI;
            KIND_SLTIU: opcode = OP_SLTIU;
            KIND_BEQ:   opcode = OP_BEQ;
            KIND_ORI:   opcode = OP_ORI;
            KIND_BNE:   opcode = OP_BNE;
            KIND_LW:    opcode = OP_LW;
            KIND_SW:    opcode = OP_SW;
        endcase
    end

    always_comb begin
        word    = {opcode, rs, rt, imm};
        illegal = 1'b0;
        if (kind == KIND_R) begin
            word    = {OP_R, rs, rt, rd, 5'd0, funct};
            illegal = !isLegalFunct(funct);
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder/loader writing packed words to imem from a programmable base.
// Optional INSTR_ENC_BRANCH_REL_EN: BEQ/BNE immediates are absolute word indices converted to relative offsets.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic              last_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic [15:0]       count_o,
    output logic              done_o,
    output logic [1:0]        err_o
);

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    EncState           state;
    EncState           stateNext;
    logic [ADDR_W-1:0] base;
    logic              accept;
    logic              illegal;
    logic              hitLimit;
    logic [15:0]       immEff;
    logic [31:0]       packedWord;

    assign accept   = req_valid_i && req_ready_o;
    assign hitLimit = !illegal && (count_o + 16'd1 == MAX_COUNT);

    // Branch targets become offsets relative to the slot after the branch itself.
    always_comb begin
        immEff = imm_i;
`ifdef INSTR_ENC_BRANCH_REL_EN
        if (kind_i == KIND_BEQ || kind_i == KIND_BNE) begin
            immEff = imm_i - (count_o + 16'd1);
        end
`endif
    end

    instr_field_pack fieldPack (
        .kind    (InstrKind'(kind_i)),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .funct   (funct_i),
        .imm     (immEff),
        .word    (packedWord),
        .illegal (illegal)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (start_i) stateNext = RUN;
            RUN:        if (accept && (last_i || hitLimit)) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state == RUN) && (count_o < MAX_COUNT);
        done_o      = (state == DONE);
    end

    // Illegal descriptors are consumed silently apart from the sticky error bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base    <= '0;
            count_o <= '0;
            err_o   <= '0;
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else begin
            we_o <= 1'b0;
            if (state != RUN && start_i) begin
                base    <= base_i;
                count_o <= '0;
                err_o   <= '0;
            end else if (accept) begin
                if (illegal) begin
                    err_o[0] <= 1'b1;
                end else begin
                    we_o    <= 1'b1;
                    waddr_o <= base + (ADDR_W'(count_o) << 2);
                    wdata_o <= packedWord;
                    count_o <= count_o + 16'd1;
                    if (!last_i && hitLimit) err_o[1] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized sessions against a behavioural model.
module tb_instr_encoder;

    localparam int MAXW = 256;

    logic        clk = 1'b0;
    logic        rstN;
    logic        startI;
    logic        startSmall;
    logic [31:0] baseI;
    logic        validI;
    logic [2:0]  kindI;
    logic [4:0]  rsI, rtI, rdI;
    logic [5:0]  functI;
    logic [15:0] immI;
    logic        lastI;

    logic        ready, we, done;
    logic [31:0] waddr, wdata;
    logic [15:0] count;
    logic [1:0]  err;
    logic        sReady, sWe, sDone;
    logic [31:0] sWaddr, sWdata;
    logic [15:0] sCount;
    logic [1:0]  sErr;

    int checks = 0;
    int failures = 0;

    bit          mRun;
    int          mCount;
    logic [31:0] mBase;
    logic [1:0]  mErr;
    bit          expWe;
    logic [31:0] expAddr, expData;

    int opTable [8] = '{0, 8, 9, 4, 13, 5, 35, 43};
    logic [5:0] legalFn [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .MAX_WORDS(MAXW)) dut (
        .clk_i(clk), .rst_i(rstN), .start_i(startI), .base_i(baseI),
        .req_valid_i(validI), .req_ready_o(ready), .kind_i(kindI),
        .rs_i(rsI), .rt_i(rtI), .rd_i(rdI), .funct_i(functI), .imm_i(immI),
        .last_i(lastI), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .count_o(count), .done_o(done), .err_o(err)
    );

    instr_encoder #(.ADDR_W(32), .MAX_WORDS(4)) dutSmall (
        .clk_i(clk), .rst_i(rstN), .start_i(startSmall), .base_i(baseI),
        .req_valid_i(validI), .req_ready_o(sReady), .kind_i(kindI),
        .rs_i(rsI), .rt_i(rtI), .rd_i(rdI), .funct_i(functI), .imm_i(immI),
        .last_i(lastI), .we_o(sWe), .waddr_o(sWaddr), .wdata_o(sWdata),
        .count_o(sCount), .done_o(sDone), .err_o(sErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic bit refLegal(input int kind, input int funct);
        return kind != 0 || funct == 32 || funct == 34 || funct == 36 || funct == 37 || funct == 42;
    endfunction

    function automatic logic [31:0] refWord(input int kind, input int rs, input int rt, input int rd,
                                            input int funct, input int imm, input int cnt);
        longint v;
        int off;
        off = imm;
`ifdef INSTR_ENC_BRANCH_REL_EN
        if (kind == 3 || kind == 5) off = (imm - cnt - 1) & 'hFFFF;
`else
        if (cnt < 0) off = imm;
`endif
        if (kind == 0)
            v = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(funct);
        else
            v = longint'(opTable[kind]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(off);
        return v[31:0];
    endfunction

    task automatic resetModel();
        mRun   = 1'b0;
        mCount = 0;
        mBase  = '0;
        mErr   = '0;
        expWe  = 1'b0;
    endtask

    // One clock: advance the model from the current inputs, then compare the main DUT after the edge.
    task automatic applyStimulus();
        bit accept;
        bit legal;
        accept = validI && mRun && (mCount < MAXW);
        expWe  = 1'b0;
        if (!mRun && startI) begin
            mRun   = 1'b1;
            mCount = 0;
            mErr   = '0;
            mBase  = baseI;
        end else if (accept) begin
            legal = refLegal(int'(kindI), int'(functI));
            if (legal) begin
                expWe   = 1'b1;
                expAddr = mBase + 32'(4 * mCount);
                expData = refWord(int'(kindI), int'(rsI), int'(rtI), int'(rdI), int'(functI), int'(immI), mCount);
                mCount++;
            end else begin
                mErr[0] = 1'b1;
            end
            if (lastI) begin
                mRun = 1'b0;
            end else if (legal && mCount == MAXW) begin
                mRun    = 1'b0;
                mErr[1] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("we", 32'(we), 32'(expWe));
        if (expWe) begin
            checkOutput("waddr", waddr, expAddr);
            checkOutput("wdata", wdata, expData);
        end
        checkOutput("count", 32'(count), 32'(mCount));
        checkOutput("err", 32'(err), 32'(mErr));
        checkOutput("ready", 32'(ready), 32'(mRun && mCount < MAXW));
        if (!mRun) checkOutput("doneIdle", 32'(done), 32'(done));
    endtask

    task automatic setDesc(input int kind, input int rs, input int rt, input int rd,
                           input int funct, input int imm, input bit last);
        validI = 1'b1;
        kindI  = 3'(kind);
        rsI    = 5'(rs);
        rtI    = 5'(rt);
        rdI    = 5'(rd);
        functI = 6'(funct);
        immI   = 16'(imm);
        lastI  = last;
    endtask

    task automatic startSession(input logic [31:0] base);
        startI = 1'b1;
        baseI  = base;
        validI = 1'b0;
        applyStimulus();
        startI = 1'b0;
    endtask

    task automatic randomDesc(input bit noLast);
        validI = ($urandom_range(0, 3) != 0);
        kindI  = 3'($urandom_range(0, 7));
        rsI    = 5'($urandom);
        rtI    = 5'($urandom);
        rdI    = 5'($urandom);
        functI = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legalFn[$urandom_range(0, 4)];
        immI   = 16'($urandom);
        lastI  = noLast ? 1'b0 : ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; startI = 1'b0; startSmall = 1'b0; baseI = '0; validI = 1'b0;
        kindI = '0; rsI = '0; rtI = '0; rdI = '0; functI = '0; immI = '0; lastI = 1'b0;
        resetModel();
        #3;
        checkOutput("rstWe", 32'(we), 32'd0);
        checkOutput("rstWaddr", waddr, 32'd0);
        checkOutput("rstWdata", wdata, 32'd0);
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstReady", 32'(ready), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Single ADDI with last
        startSession(32'h100);
        setDesc(1, 0, 8, 0, 0, 5, 1'b1);
        applyStimulus();
        validI = 1'b0;
        checkOutput("t1Data", wdata, 32'h2008_0005);
        checkOutput("t1Addr", waddr, 32'h100);
        checkOutput("t1Count", 32'(count), 32'd1);
        checkOutput("t1Done", 32'(done), 32'd1);
        applyStimulus();
        checkOutput("t1DoneHold", 32'(done), 32'd1);

        // Back-to-back R / LW / SW
        startSession(32'h100);
        setDesc(0, 1, 2, 3, 32, 0, 1'b0);
        applyStimulus();
        checkOutput("b2bData0", wdata, 32'h0022_1820);
        checkOutput("b2bAddr0", waddr, 32'h100);
        setDesc(6, 1, 2, 0, 0, 4, 1'b0);
        applyStimulus();
        checkOutput("b2bData1", wdata, 32'h8C22_0004);
        checkOutput("b2bAddr1", waddr, 32'h104);
        setDesc(7, 1, 2, 0, 0, 4, 1'b1);
        applyStimulus();
        checkOutput("b2bData2", wdata, 32'hAC22_0004);
        checkOutput("b2bAddr2", waddr, 32'h108);
        validI = 1'b0;

        // Illegal funct consumed without a write
        startSession(32'h200);
        setDesc(0, 1, 2, 3, 0, 0, 1'b0);
        applyStimulus();
        checkOutput("illWe", 32'(we), 32'd0);
        checkOutput("illErr", 32'(err), 32'd1);
        setDesc(1, 0, 8, 0, 0, 5, 1'b1);
        applyStimulus();
        checkOutput("illAddr", waddr, 32'h200);
        checkOutput("illCount", 32'(count), 32'd1);
        checkOutput("illErrHold", 32'(err), 32'd1);
        validI = 1'b0;

        // Branch encoding after two words
        startSession(32'h0);
        setDesc(1, 0, 8, 0, 0, 5, 1'b0);
        applyStimulus();
        applyStimulus();
`ifdef INSTR_ENC_BRANCH_REL_EN
        setDesc(3, 1, 2, 0, 0, 0, 1'b1);
        applyStimulus();
        checkOutput("beqData", wdata, 32'h1022_FFFD);
`else
        setDesc(3, 1, 2, 0, 0, 3, 1'b1);
        applyStimulus();
        checkOutput("beqData", wdata, 32'h1022_0003);
`endif
        validI = 1'b0;

        // Overflow on the MAX_WORDS=4 instance
        startSmall = 1'b1;
        baseI = 32'h40;
        applyStimulus();
        startSmall = 1'b0;
        setDesc(1, 0, 8, 0, 0, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("ovfWe", 32'(sWe), 32'd1);
        end
        checkOutput("ovfAddr", sWaddr, 32'h4C);
        checkOutput("ovfData", sWdata, 32'h2008_0005);
        checkOutput("ovfDone", 32'(sDone), 32'd1);
        checkOutput("ovfErr", 32'(sErr), 32'd2);
        checkOutput("ovfReady", 32'(sReady), 32'd0);
        checkOutput("ovfCount", 32'(sCount), 32'd4);
        applyStimulus();
        checkOutput("ovfFifthWe", 32'(sWe), 32'd0);
        checkOutput("ovfFifthCount", 32'(sCount), 32'd4);
        validI = 1'b0;

        // Async reset with a write in flight
        startSession(32'h300);
        setDesc(1, 0, 8, 0, 0, 5, 1'b0);
        applyStimulus();
        rstN = 1'b0;
        #1;
        checkOutput("midRstWe", 32'(we), 32'd0);
        checkOutput("midRstCount", 32'(count), 32'd0);
        checkOutput("midRstReady", 32'(ready), 32'd0);
        checkOutput("midRstWaddr", waddr, 32'd0);
        checkOutput("midRstWdata", wdata, 32'd0);
        resetModel();
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus();
        applyStimulus();
        startSession(32'h300);
        checkOutput("restartCount", 32'(count), 32'd0);
        setDesc(1, 0, 8, 0, 0, 5, 1'b1);
        applyStimulus();
        checkOutput("restartAddr", waddr, 32'h300);
        validI = 1'b0;

        // Randomized sessions; session 3 never sends last and must overflow
        for (int s = 0; s < 24; s++) begin
            bit noLast;
            noLast = (s == 3);
            randomDesc(noLast);
            startI = 1'b1;
            baseI  = $urandom & 32'hFFFF_FFFC;
            applyStimulus();
            for (int c = 0; c < 1000 && mRun; c++) begin
                randomDesc(noLast);
                startI = ($urandom_range(0, 15) == 0);
                baseI  = $urandom & 32'hFFFF_FFFC;
                applyStimulus();
            end
            startI = 1'b0;
            validI = 1'b0;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
